// File: rtl/scope_adc_sampler.sv
// scope_adc_sampler: programmable ADC clock generator, capture, pipeline-latency discard
// and 2^D block averager feeding the capture buffer.
// Optional feature: define SCOPE_PEAK_DETECT_EN to track per-window min/max on oMin/oMax;
// otherwise oMin/oMax are tied to zero.
`timescale 1ns/1ps
module scope_adc_sampler #(
    parameter int unsigned pDataBits     = 8,
    parameter int unsigned pDivBits      = 16,
    parameter int unsigned pMaxDecimLog2 = 4,
    parameter int unsigned pAdcPipe      = 3
) (
    input  logic                                 iCLK,
    input  logic                                 iRST_N,
    input  logic                                 iEnable,
    input  logic [pDivBits-1:0]                  iHalfPeriod,
    input  logic [$clog2(pMaxDecimLog2+1)-1:0]   iDecimLog2,
    input  logic [pDataBits-1:0]                 iADC_Byte,
    output logic                                 oADC_CLK,
    output logic                                 oADC_nOE,
    output logic [pDataBits-1:0]                 oSample,
    output logic                                 oSampleValid,
    output logic [pDataBits-1:0]                 oMin,
    output logic [pDataBits-1:0]                 oMax
);

    localparam int unsigned DecW  = $clog2(pMaxDecimLog2 + 1);
    localparam int unsigned AccW  = pDataBits + pMaxDecimLog2;
    localparam int unsigned WinW  = pMaxDecimLog2 + 1;
    localparam int unsigned DiscW = (pAdcPipe > 0) ? $clog2(pAdcPipe + 1) : 1;

    localparam logic [DecW-1:0]     MaxDec   = DecW'(pMaxDecimLog2);
    localparam logic [pDivBits-1:0] DivOne   = pDivBits'(1);
    localparam logic [WinW-1:0]     WinOne   = WinW'(1);
    localparam logic [DiscW-1:0]    DiscOne  = DiscW'(1);
    localparam logic [DiscW-1:0]    DiscLoad = DiscW'(pAdcPipe);

    logic [pDivBits-1:0]  div_cnt_q, div_cnt_d;
    logic [pDivBits-1:0]  half_q, half_d;
    logic                 adc_clk_q, adc_clk_d;
    logic                 noe_q, noe_d;
    logic [DiscW-1:0]     disc_q, disc_d;
    logic [AccW-1:0]      acc_q, acc_d;
    logic [WinW-1:0]      win_q, win_d;
    logic [DecW-1:0]      dec_q, dec_d;
    logic [pDataBits-1:0] sample_q, sample_d;
    logic                 valid_q, valid_d;

    logic [pDivBits-1:0]  half_eff;
    logic [DecW-1:0]      dec_in, dec_eff;
    logic                 wrap, accept, win_first, win_last;
    logic [WinW-1:0]      win_next;
    logic [AccW-1:0]      acc_sum, avg;

    // Shared decode: half-period wrap, capture qualification and window bookkeeping
    always_comb begin
        half_eff  = (iHalfPeriod == '0) ? DivOne : iHalfPeriod;
        dec_in    = (iDecimLog2 > MaxDec) ? MaxDec : iDecimLog2;
        wrap      = (div_cnt_q + DivOne) == half_q;
        // A capture is the wrap that drops the ADC clock; the first enabled cycle never
        // captures because the clock is still low coming out of idle.
        accept    = iEnable && !noe_q && wrap && adc_clk_q && (disc_q == '0);
        win_first = (win_q == '0);
        dec_eff   = win_first ? dec_in : dec_q;
        win_next  = win_q + WinOne;
        win_last  = win_next == (WinOne << dec_eff);
        acc_sum   = acc_q + AccW'(iADC_Byte);
        avg       = acc_sum >> dec_eff;
    end

    // Next state of the half-period divider, ADC clock and output enable
    always_comb begin
        div_cnt_d = div_cnt_q;
        half_d    = half_q;
        adc_clk_d = adc_clk_q;
        noe_d     = noe_q;
        if (!iEnable) begin
            div_cnt_d = '0;
            half_d    = half_eff;
            adc_clk_d = 1'b0;
            noe_d     = 1'b1;
        end else begin
            noe_d = 1'b0;
            if (wrap) begin
                // New half-period length only takes effect at a phase boundary
                div_cnt_d = '0;
                half_d    = half_eff;
                adc_clk_d = ~adc_clk_q;
            end else begin
                div_cnt_d = div_cnt_q + DivOne;
            end
        end
    end

    // Next state of discard counter, accumulator and averaged output
    always_comb begin
        disc_d   = disc_q;
        acc_d    = acc_q;
        win_d    = win_q;
        dec_d    = dec_q;
        sample_d = sample_q;
        valid_d  = 1'b0;
        if (!iEnable || noe_q) begin
            // Idle or first enabled cycle: drop any partial window, re-arm the discard
            disc_d = DiscLoad;
            acc_d  = '0;
            win_d  = '0;
        end else if (wrap && adc_clk_q && (disc_q != '0)) begin
            disc_d = disc_q - DiscOne;
        end else if (accept) begin
            if (win_first) begin
                dec_d = dec_in;
            end
            if (win_last) begin
                sample_d = avg[pDataBits-1:0];
                valid_d  = 1'b1;
                acc_d    = '0;
                win_d    = '0;
            end else begin
                acc_d = acc_sum;
                win_d = win_next;
            end
        end
    end

    // State registers
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            div_cnt_q <= '0;
            half_q    <= DivOne;
            adc_clk_q <= 1'b0;
            noe_q     <= 1'b1;
            disc_q    <= '0;
            acc_q     <= '0;
            win_q     <= '0;
            dec_q     <= '0;
            sample_q  <= '0;
            valid_q   <= 1'b0;
        end else begin
            div_cnt_q <= div_cnt_d;
            half_q    <= half_d;
            adc_clk_q <= adc_clk_d;
            noe_q     <= noe_d;
            disc_q    <= disc_d;
            acc_q     <= acc_d;
            win_q     <= win_d;
            dec_q     <= dec_d;
            sample_q  <= sample_d;
            valid_q   <= valid_d;
        end
    end

    assign oADC_CLK     = adc_clk_q;
    assign oADC_nOE     = noe_q;
    assign oSample      = sample_q;
    assign oSampleValid = valid_q;

`ifdef SCOPE_PEAK_DETECT_EN
    logic [pDataBits-1:0] run_min_q, run_min_d, run_max_q, run_max_d;
    logic [pDataBits-1:0] min_q, min_d, max_q, max_d;
    logic [pDataBits-1:0] cur_min, cur_max;

    // Running extremes, seeded by the first capture of each window
    always_comb begin
        cur_min   = (win_first || (iADC_Byte < run_min_q)) ? iADC_Byte : run_min_q;
        cur_max   = (win_first || (iADC_Byte > run_max_q)) ? iADC_Byte : run_max_q;
        run_min_d = run_min_q;
        run_max_d = run_max_q;
        min_d     = min_q;
        max_d     = max_q;
        if (accept) begin
            run_min_d = cur_min;
            run_max_d = cur_max;
            if (win_last) begin
                min_d = cur_min;
                max_d = cur_max;
            end
        end
    end

    // Peak registers
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            run_min_q <= '0;
            run_max_q <= '0;
            min_q     <= '0;
            max_q     <= '0;
        end else begin
            run_min_q <= run_min_d;
            run_max_q <= run_max_d;
            min_q     <= min_d;
            max_q     <= max_d;
        end
    end

    assign oMin = min_q;
    assign oMax = max_q;
`else
    assign oMin = '0;
    assign oMax = '0;
`endif

endmodule

// File: tb/tb_scope_adc_sampler.sv
// Self-checking bench for scope_adc_sampler: queue-based reference model compared every
// cycle, plus directed scenarios with hand-computed expectations.
`timescale 1ns/1ps
module tb_scope_adc_sampler;

    localparam int PIPE = 3;
    localparam int MAXD = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic [15:0] hp = 16'd2;
    logic [2:0]  dl = 3'd0;
    logic [7:0]  adc_byte = 8'd0;
    logic        adc_clk, noe, sval;
    logic [7:0]  samp, mn, mx;

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;
    int seq[$];

    scope_adc_sampler dut (
        .iCLK        (clk),
        .iRST_N      (rst_n),
        .iEnable     (en),
        .iHalfPeriod (hp),
        .iDecimLog2  (dl),
        .iADC_Byte   (adc_byte),
        .oADC_CLK    (adc_clk),
        .oADC_nOE    (noe),
        .oSample     (samp),
        .oSampleValid(sval),
        .oMin        (mn),
        .oMax        (mx)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    bit        m_clk = 0, m_noe = 1, m_valid = 0;
    logic [7:0] m_samp = 0, m_min = 0, m_max = 0;
    int        elapsed = 0, cur_half = 1, cap_cnt = 0, m_d = 0;
    int        win[$];

    function automatic int eff_h(input int h);
        return (h == 0) ? 1 : h;
    endfunction

    task automatic model_capture(input int b);
        int sum, lo, hi;
        cap_cnt++;
        if (cap_cnt <= PIPE) return;
        if (win.size() == 0) m_d = (int'(dl) > MAXD) ? MAXD : int'(dl);
        win.push_back(b);
        if (win.size() == (1 << m_d)) begin
            sum = 0; lo = 255; hi = 0;
            foreach (win[i]) begin
                sum += win[i];
                if (win[i] < lo) lo = win[i];
                if (win[i] > hi) hi = win[i];
            end
            m_samp  = 8'(sum >> m_d);
            m_valid = 1;
`ifdef SCOPE_PEAK_DETECT_EN
            m_min = 8'(lo);
            m_max = 8'(hi);
`endif
            win.delete();
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_clk = 0; m_noe = 1; m_valid = 0; m_samp = 0; m_min = 0; m_max = 0;
            elapsed = 0; cur_half = 1; cap_cnt = 0; win.delete();
        end else begin
            m_valid = 0;
            if (!en) begin
                m_clk = 0; m_noe = 1; elapsed = 0; cur_half = eff_h(int'(hp));
                cap_cnt = 0; win.delete();
            end else begin
                m_noe = 0;
                elapsed++;
                if (elapsed == cur_half) begin
                    elapsed  = 0;
                    cur_half = eff_h(int'(hp));
                    if (m_clk) model_capture(int'(adc_byte));
                    m_clk = !m_clk;
                end
            end
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (rst_n) begin
            check("m_adc_clk", 32'(adc_clk), 32'(m_clk));
            check("m_noe", 32'(noe), 32'(m_noe));
            check("m_valid", 32'(sval), 32'(m_valid));
            check("m_sample", 32'(samp), 32'(m_samp));
            check("m_min", 32'(mn), 32'(m_min));
            check("m_max", 32'(mx), 32'(m_max));
        end
    end

    // ---------------- helpers ----------------
    task automatic phase_len(input logic lvl, output int n);
        n = 0;
        while (adc_clk === lvl && n < 1000) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic feed_wait(input int max_cyc, output bit got, output logic [7:0] s,
                             output logic [7:0] lo, output logic [7:0] hi, output int at);
        logic prev;
        got = 0; s = 0; lo = 0; hi = 0; at = 0;
        prev = adc_clk;
        for (int i = 0; i < max_cyc && !got; i++) begin
            @(negedge clk);
            if (sval === 1'b1) begin
                got = 1; s = samp; lo = mn; hi = mx; at = cyc;
            end
            if (prev === 1'b1 && adc_clk === 1'b0 && seq.size() > 0) adc_byte = 8'(seq.pop_front());
            prev = adc_clk;
        end
        if (!got) begin
            n_cmp++; n_fail++;
            $display("FAIL strobe_timeout: got no strobe, expected one within %0d cycles", max_cyc);
        end
    endtask

    task automatic start(input int h, input int d, input int first_byte);
        en = 0; hp = 16'(h); dl = 3'(d); adc_byte = 8'(first_byte);
        repeat (2) @(negedge clk);
        en = 1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        bit got;
        logic [7:0] s, lo, hi;
        int at0, at1, n, exp_pk_lo, exp_pk_hi;

`ifdef SCOPE_PEAK_DETECT_EN
        exp_pk_lo = 10; exp_pk_hi = 41;
`else
        exp_pk_lo = 0;  exp_pk_hi = 0;
`endif
        repeat (3) @(negedge clk);
        check("rst_adc_clk", 32'(adc_clk), 0);
        check("rst_noe", 32'(noe), 1);
        check("rst_sample", 32'(samp), 0);
        check("rst_valid", 32'(sval), 0);
        check("rst_min", 32'(mn), 0);
        check("rst_max", 32'(mx), 0);
        rst_n = 1;
        @(negedge clk);

        // H=0 and H=1: toggle every system clock
        start(0, 0, 0);
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            check("h0_toggle", 32'(adc_clk), 32'(i % 2));
        end
        check("run_noe", 32'(noe), 0);
        start(1, 0, 0);
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            check("h1_toggle", 32'(adc_clk), 32'(i % 2));
        end

        // Half-period change 4 -> 2 mid-phase
        start(4, 0, 0);
        n = 0;
        while (adc_clk !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("first_rise_cycles", 32'(n), 4);
        hp = 16'd2;
        phase_len(1'b1, n); check("hp_old_high", 32'(n), 4);
        phase_len(1'b0, n); check("hp_new_low", 32'(n), 2);
        phase_len(1'b1, n); check("hp_new_high", 32'(n), 2);

        // Ramp, H=2, D=0: bytes 0,1,2 discarded, then one strobe per ADC period
        seq.delete();
        for (int i = 1; i < 10; i++) seq.push_back(i);
        start(2, 0, 0);
        feed_wait(200, got, s, lo, hi, at0); check("ramp_s0", 32'(s), 3);
        feed_wait(200, got, s, lo, hi, at1); check("ramp_s1", 32'(s), 4);
        check("ramp_spacing", 32'(at1 - at0), 4);
        feed_wait(200, got, s, lo, hi, at0); check("ramp_s2", 32'(s), 5);

        // D=2 average of 10,20,30,41 after discarding 1,2,3
        seq = '{2, 3, 10, 20, 30, 41, 0, 0, 0, 0};
        start(3, 2, 1);
        feed_wait(400, got, s, lo, hi, at0);
        check("avg4_sample", 32'(s), 25);
        check("avg4_min", 32'(lo), 32'(exp_pk_lo));
        check("avg4_max", 32'(hi), 32'(exp_pk_hi));

        // Discard 5,6,7 then 8 is the first strobe
        seq = '{6, 7, 8, 9, 9};
        start(2, 0, 5);
        feed_wait(200, got, s, lo, hi, at0); check("discard_first", 32'(s), 8);
        feed_wait(200, got, s, lo, hi, at0); check("discard_second", 32'(s), 9);

        // Async reset mid-window while ADC clock is high
        seq = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12};
        start(3, 3, 0);
        repeat (60) @(negedge clk);
        n = 0;
        while (adc_clk !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        #2 rst_n = 0;
        #1;
        check("amid_rst_clk", 32'(adc_clk), 0);
        check("amid_rst_noe", 32'(noe), 1);
        check("amid_rst_valid", 32'(sval), 0);
        check("amid_rst_sample", 32'(samp), 0);
        en = 0;
        @(negedge clk);
        rst_n = 1;
        seq = '{51, 52, 53, 54};
        start(2, 0, 50);
        feed_wait(200, got, s, lo, hi, at0); check("rst_rediscard", 32'(s), 53);

        // Randomised run against the model
        hp = 16'd2; dl = 3'd0; en = 1;
        for (int i = 0; i < 15000; i++) begin
            @(negedge clk);
            adc_byte = 8'($urandom);
            if ($urandom_range(0, 199) == 0) hp = 16'($urandom_range(0, 5));
            if ($urandom_range(0, 299) == 0) dl = 3'($urandom_range(0, 7));
            if (en && $urandom_range(0, 499) == 0) en = 0;
            else if (!en && $urandom_range(0, 9) == 0) en = 1;
            if ($urandom_range(0, 2999) == 0) begin
                #2 rst_n = 0;
                @(negedge clk);
                rst_n = 1;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no completion, expected finish before 2 ms");
        $fatal(1, "watchdog");
    end

endmodule
